load_store_unit: RTL

//  MEM-stage load/store controller that sits directly upstream of the 128-word DataMemory.

---
 rtl/load_store_unit.sv | 99 +++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage byte/half/word load-store controller in front of a word-write-only DataMemory.
// Sub-word stores read-modify-write the addressed word; misaligned, reserved or out-of-range requests fault.
module load_store_unit #(
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req,
    input  logic                  i_req_write,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_signed,
    input  logic [31:0]           i_req_addr,
    input  logic [31:0]           i_req_wdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_fault,
    output logic [31:0]           o_rdata,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [31:0]           o_mem_wdata,
    output logic                  o_mem_read,
    output logic                  o_mem_write,
    input  logic [31:0]           i_mem_rdata
);
    typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;
    state_t                r_state, w_next;
    logic                  r_write, r_signed, r_done, r_fault;
    logic [1:0]            r_size;
    logic [ADDR_WIDTH+1:0] r_addr;
    logic [31:0]           r_wdata, r_rdata;
    logic                  w_accept, w_fault;
    logic [4:0]            w_shamt;
    logic [31:0]           w_lane, w_load, w_mask, w_merge;

    always_comb begin
        w_accept = i_req && (r_state == IDLE);
        w_fault  = (i_req_size == 2'b11) ||
                   (i_req_size == 2'b01 && i_req_addr[0]) ||
                   (i_req_size == 2'b10 && i_req_addr[1:0] != 2'b00) ||
                   (i_req_addr[31:ADDR_WIDTH+2] != '0);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (w_accept && !w_fault) ? ((i_req_write && i_req_size == 2'b10) ? WR : RD) : IDLE;
            RD:      w_next = CAP;
            CAP:     w_next = r_write ? WR : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Halves are always aligned, so one byte-granular shift serves both lane sizes.
    always_comb begin
        w_shamt = {r_addr[1:0], 3'b000};
        w_lane  = i_mem_rdata >> w_shamt;
        w_load  = (r_size == 2'b00) ? {{24{r_signed & w_lane[7]}}, w_lane[7:0]} :
                  (r_size == 2'b01) ? {{16{r_signed & w_lane[15]}}, w_lane[15:0]} : i_mem_rdata;
        w_mask  = ((r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << w_shamt;
        w_merge = (i_mem_rdata & ~w_mask) | ((r_wdata << w_shamt) & w_mask);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_done   <= 1'b0;
            r_fault  <= 1'b0;
            r_write  <= 1'b0;
            r_signed <= 1'b0;
            r_size   <= 2'b00;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= (w_accept && w_fault) || (r_state == CAP && !r_write) || (r_state == WR);
            r_fault <= w_accept && w_fault;
            if (w_accept) begin
                r_write  <= i_req_write;
                r_size   <= i_req_size;
                r_signed <= i_req_signed;
                r_addr   <= i_req_addr[ADDR_WIDTH+1:0];
                r_wdata  <= i_req_wdata;
            end
            if (r_state == CAP && !r_write) r_rdata <= w_load;
            if (r_state == CAP && r_write) r_wdata <= w_merge;
        end
    end

    always_comb begin
        o_busy      = (r_state != IDLE);
        o_done      = r_done;
        o_fault     = r_fault;
        o_rdata     = r_rdata;
        o_mem_addr  = r_addr[ADDR_WIDTH+1:2];
        o_mem_wdata = r_wdata;
        o_mem_read  = (r_state == RD);
        o_mem_write = (r_state == WR);
    end
endmodule
